// File: rtl/avalon_pkg.sv
// Shared types and widths for the Avalon-MM wait-state injector.
package avalon_pkg;

  localparam int WAIT_W   = 4;
  localparam int WAIT_MAX = (1 << WAIT_W) - 1;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    ISSUE,
    CAPTURE,
    RESP
  } avalon_state_t;

  typedef enum logic {
    KIND_READ,
    KIND_WRITE
  } avalon_kind_t;

  // A request carrying m_read is always treated as a read, even if m_write is also high.
  function automatic avalon_kind_t kind_of(input logic rd);
    return rd ? KIND_READ : KIND_WRITE;
  endfunction

endpackage

// File: rtl/avalon_wait_counter.sv
// Loadable down-counter that sets the stall length of one Avalon transaction.
module avalon_wait_counter
  import avalon_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_value,
  input  logic              dec,
  output logic [WAIT_W-1:0] value,
  output logic              done
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == WAIT_W'(1));

endmodule

// File: rtl/avalon_wait_injector.sv
// Avalon-MM wait-state injector: latches a master request, stalls it for a fixed
// number of cycles, then performs exactly one single-cycle access to the memory.
module avalon_wait_injector
  import avalon_pkg::*;
#(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_address,
  input  logic        m_read,
  input  logic        m_write,
  input  logic [3:0]  m_byteenable,
  input  logic [31:0] m_writedata,
  output logic [31:0] m_readdata,
  output logic        m_waitrequest,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [3:0]  s_byteenable,
  output logic [31:0] s_writedata,
  input  logic [31:0] s_readdata,
  output logic        protocol_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  if (READ_WAIT > WAIT_MAX || WRITE_WAIT > WAIT_MAX) begin : g_param_check
    $fatal(1, "avalon_wait_injector: READ_WAIT and WRITE_WAIT must be within 0..15");
  end

  localparam logic [WAIT_W-1:0] READ_LOAD  = WAIT_W'(READ_WAIT);
  localparam logic [WAIT_W-1:0] WRITE_LOAD = WAIT_W'(WRITE_WAIT);

  avalon_state_t state;
  avalon_kind_t  kind_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          s_read_q;
  logic          s_write_q;
  logic          err_q;
  logic [15:0]   rd_cnt_q;
  logic [15:0]   wr_cnt_q;

  logic              req;
  logic [WAIT_W-1:0] load_value;
  logic              cnt_load;
  logic              cnt_dec;
  logic [WAIT_W-1:0] cnt_value;
  logic              cnt_done;
  logic              violation;

  assign req        = m_read | m_write;
  assign load_value = m_read ? READ_LOAD : WRITE_LOAD;
  assign cnt_load   = (state == IDLE) && req;
  assign cnt_dec    = (state == COUNT);

  avalon_wait_counter u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (load_value),
    .dec        (cnt_dec),
    .value      (cnt_value),
    .done       (cnt_done)
  );

  // Once a transaction is latched the master must hold its request unchanged until RESP.
  assign violation = (state != IDLE) &&
                     (!req || (m_address != addr_q) || (kind_of(m_read) != kind_q));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      kind_q    <= KIND_READ;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      s_read_q  <= 1'b0;
      s_write_q <= 1'b0;
      err_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      s_read_q  <= 1'b0;
      s_write_q <= 1'b0;
      if (violation) begin
        err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= m_address;
            be_q    <= m_byteenable;
            wdata_q <= m_writedata;
            kind_q  <= kind_of(m_read);
            if (m_read && m_write) begin
              err_q <= 1'b1;
            end
            if (load_value != '0) begin
              state <= COUNT;
            end else begin
              state     <= ISSUE;
              s_read_q  <= m_read;
              s_write_q <= ~m_read;
            end
          end
        end
        COUNT: begin
          // A zero count here can only come from an upset; recover by issuing.
          if (cnt_done || cnt_value == '0) begin
            state     <= ISSUE;
            s_read_q  <= (kind_q == KIND_READ);
            s_write_q <= (kind_q == KIND_WRITE);
          end
        end
        ISSUE: begin
          state <= (kind_q == KIND_READ) ? CAPTURE : RESP;
        end
        CAPTURE: begin
          rdata_q <= s_readdata;
          state   <= RESP;
        end
        RESP: begin
          if (kind_q == KIND_READ) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
          end else begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_waitrequest = !reset ? 1'b1 :
                         (state == IDLE) ? req : (state != RESP);
  assign m_readdata    = rdata_q;
  assign s_address     = addr_q;
  assign s_byteenable  = be_q;
  assign s_writedata   = wdata_q;
  assign s_read        = s_read_q;
  assign s_write       = s_write_q;
  assign protocol_err  = err_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule
